// File: rtl/channel_tee_n.sv
// channel_tee_n: N-way channel tee with select-out chain, owner tracking
// and contention reporting. Option: CHANNEL_TEE_N_CONTENTION_COUNT_EN.
module channel_tee_n #(
  parameter int NUM_DEVICES = 2,
  parameter int DEVICE_FIRST = 1,
  parameter logic [NUM_DEVICES-1:0] BYPASS_MASK = '0,
  parameter int OW = $clog2(NUM_DEVICES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               b_bus_out,
  output logic [7:0]               b_bus_in,
  input  logic                     b_operational_out,
  input  logic                     b_hold_out,
  input  logic                     b_select_out,
  input  logic                     b_address_out,
  input  logic                     b_command_out,
  input  logic                     b_service_out,
  input  logic                     b_suppress_out,
  output logic                     b_request_in,
  output logic                     b_select_in,
  output logic                     b_operational_in,
  output logic                     b_address_in,
  output logic                     b_status_in,
  output logic                     b_service_in,
  input  logic [7:0]               a_bus_in,
  output logic [7:0]               a_bus_out,
  output logic                     a_operational_out,
  output logic                     a_hold_out,
  output logic                     a_select_out,
  output logic                     a_address_out,
  output logic                     a_command_out,
  output logic                     a_service_out,
  output logic                     a_suppress_out,
  input  logic                     a_request_in,
  input  logic                     a_select_in,
  input  logic                     a_operational_in,
  input  logic                     a_address_in,
  input  logic                     a_status_in,
  input  logic                     a_service_in,
  input  logic [8*NUM_DEVICES-1:0] dev_bus_in,
  output logic [7:0]               dev_bus_out,
  input  logic [NUM_DEVICES-1:0]   dev_request_in,
  input  logic [NUM_DEVICES-1:0]   dev_operational_in,
  input  logic [NUM_DEVICES-1:0]   dev_address_in,
  input  logic [NUM_DEVICES-1:0]   dev_status_in,
  input  logic [NUM_DEVICES-1:0]   dev_service_in,
  output logic                     dev_operational_out,
  output logic                     dev_hold_out,
  output logic                     dev_address_out,
  output logic                     dev_command_out,
  output logic                     dev_service_out,
  output logic                     dev_suppress_out,
  output logic [NUM_DEVICES-1:0]   dev_selection_x,
  input  logic [NUM_DEVICES-1:0]   dev_selection_y,
  output logic                     connected,
  output logic [OW-1:0]            owner,
  output logic                     contention,
  output logic                     contention_sticky,
  output logic [7:0]               contention_count
);

  localparam int NU = NUM_DEVICES + 1;

  typedef enum logic {
    S_IDLE,
    S_CONN
  } state_t;

  state_t state;

  logic [NU-1:0] opv;
  logic [3:0]    n_on;
  logic [OW-1:0] hit_idx;
  logic          owner_on;
  logic          others_on;
  logic          contend;

  assign opv = {a_operational_in, dev_operational_in};

  always_comb begin
    n_on      = '0;
    hit_idx   = '0;
    owner_on  = 1'b0;
    others_on = 1'b0;
    for (int k = 0; k < NU; k++) begin
      if (opv[k]) begin
        n_on    = n_on + 4'd1;
        hit_idx = OW'(k);
        if (owner == OW'(k)) owner_on = 1'b1;
        else others_on = 1'b1;
      end
    end
  end

  assign contend = (state == S_IDLE) ? (n_on > 4'd1) : others_on;

  // Inbound merge: OR of all units while idle, owner only once latched
  logic [7:0] m_bus;
  logic       m_req;
  logic       m_op;
  logic       m_adr;
  logic       m_sta;
  logic       m_svc;

  always_comb begin
    m_bus = '0;
    m_op  = 1'b0;
    m_adr = 1'b0;
    m_sta = 1'b0;
    m_svc = 1'b0;
    m_req = a_request_in | (|dev_request_in);
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (state == S_IDLE || owner == OW'(i)) begin
        m_bus = m_bus | dev_bus_in[8*i +: 8];
        m_op  = m_op  | dev_operational_in[i];
        m_adr = m_adr | dev_address_in[i];
        m_sta = m_sta | dev_status_in[i];
        m_svc = m_svc | dev_service_in[i];
      end
    end
    if (state == S_IDLE || owner == OW'(NUM_DEVICES)) begin
      m_bus = m_bus | a_bus_in;
      m_op  = m_op  | a_operational_in;
      m_adr = m_adr | a_address_in;
      m_sta = m_sta | a_status_in;
      m_svc = m_svc | a_service_in;
    end
  end

  logic                   head;
  logic                   hop;
  logic [NUM_DEVICES-1:0] sel_x;

  assign head = (DEVICE_FIRST != 0) ? b_select_out : a_select_in;

  always_comb begin
    sel_x = '0;
    hop   = head;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (!BYPASS_MASK[i]) begin
        sel_x[i] = hop;
        hop      = dev_selection_y[i];
      end
    end
  end

  assign connected = (state == S_CONN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      owner               <= '0;
      contention          <= 1'b0;
      contention_sticky   <= 1'b0;
      b_bus_in            <= '0;
      b_request_in        <= 1'b0;
      b_select_in         <= 1'b0;
      b_operational_in    <= 1'b0;
      b_address_in        <= 1'b0;
      b_status_in         <= 1'b0;
      b_service_in        <= 1'b0;
      a_bus_out           <= '0;
      a_operational_out   <= 1'b0;
      a_hold_out          <= 1'b0;
      a_select_out        <= 1'b0;
      a_address_out       <= 1'b0;
      a_command_out       <= 1'b0;
      a_service_out       <= 1'b0;
      a_suppress_out      <= 1'b0;
      dev_bus_out         <= '0;
      dev_operational_out <= 1'b0;
      dev_hold_out        <= 1'b0;
      dev_address_out     <= 1'b0;
      dev_command_out     <= 1'b0;
      dev_service_out     <= 1'b0;
      dev_suppress_out    <= 1'b0;
      dev_selection_x     <= '0;
    end else begin
      // Loss of upstream operational-out drops any connection at once
      if (!b_operational_out) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (n_on == 4'd1) begin
              state <= S_CONN;
              owner <= hit_idx;
            end
          end
          S_CONN: begin
            if (!owner_on) state <= S_IDLE;
          end
        endcase
      end
      contention        <= contend;
      contention_sticky <= contention_sticky | contend;

      b_bus_in         <= m_bus;
      b_request_in     <= m_req;
      b_operational_in <= m_op;
      b_address_in     <= m_adr;
      b_status_in      <= m_sta;
      b_service_in     <= m_svc;

      a_bus_out         <= b_bus_out;
      a_operational_out <= b_operational_out;
      a_hold_out        <= b_hold_out;
      a_address_out     <= b_address_out;
      a_command_out     <= b_command_out;
      a_service_out     <= b_service_out;
      a_suppress_out    <= b_suppress_out;

      dev_bus_out         <= b_bus_out;
      dev_operational_out <= b_operational_out;
      dev_hold_out        <= b_hold_out;
      dev_address_out     <= b_address_out;
      dev_command_out     <= b_command_out;
      dev_service_out     <= b_service_out;
      dev_suppress_out    <= b_suppress_out;

      dev_selection_x <= sel_x;
      if (DEVICE_FIRST != 0) begin
        a_select_out <= hop;
        b_select_in  <= a_select_in;
      end else begin
        a_select_out <= b_select_out;
        b_select_in  <= hop;
      end
    end
  end

`ifdef CHANNEL_TEE_N_CONTENTION_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (contend && count_q != 8'hFF) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign contention_count = count_q;
`else
  assign contention_count = 8'd0;
`endif

endmodule

// File: doc/channel_tee_n.md
Name: channel_tee_n

Overview:
- N-way successor to the two-way channel tee. Fans one upstream parallel channel ("B") out to NUM_DEVICES local device ports and one downstream daisy-chain port ("A").
- Routes select-out through a configurable priority chain.
- Tracks which attached unit currently holds the channel (operational-in owner) and gates inbound bus/tags from non-owners while connected.
- Detects and reports operational-in contention. Sits between the channel front end and the local control-unit instances.

Parameters:
- NUM_DEVICES, 2: number of local device ports; legal range 1..8.
- DEVICE_FIRST, 1: 1 = select-out visits devices 0..N-1 before A; 0 = A first, then devices, returning to B.
- BYPASS_MASK, {NUM_DEVICES{1'b0}}: bit i = 1 removes device i from the selection chain.
- OW, $clog2(NUM_DEVICES+1): owner index width; derived, not to be overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- b_bus_out / b_bus_in  in/out  8  upstream bus
- b_{operational,hold,select,address,command,service,suppress}_out  in  1 each  upstream outbound tags
- b_{request,select,operational,address,status,service}_in  out  1 each  upstream inbound tags
- a_bus_in / a_bus_out  in/out  8  downstream bus
- a_{...}_out  out  1 each  downstream outbound tags, same set as b_*_out
- a_{...}_in  in  1 each  downstream inbound tags, same set as b_*_in
- dev_bus_in  in  8*N  device bus-in, device i at [8i+7:8i]
- dev_bus_out  out  8  shared bus-out to all devices
- dev_{request,operational,address,status,service}_in  in  N  device inbound tags
- dev_{operational,hold,address,command,service,suppress}_out  out  1 each  broadcast outbound tags
- dev_selection_x  out  N  select-out into device i
- dev_selection_y  in  N  select-out returned from device i
- connected  out  1  an owner is latched
- owner  out  OW  owning unit; 0..N-1 = device, N = downstream A
- contention  out  1  one-cycle pulse on detected contention
- contention_sticky  out  1  set on contention; cleared only by reset
- contention_count  out  8  saturating contention count

Behaviour:
- Reset: all outputs 0; FSM in IDLE; owner = 0.
- Latency: every output is registered, 1 clk from inputs.
- Outbound path:
  - a_*_out and dev_*_out copy the corresponding b_*_out; dev_bus_out and a_bus_out copy b_bus_out.
  - a_select_out is handled by the selection chain.
- Selection chain: combinational between hops, registered at each output.
  - Ordered list of non-bypassed devices, ascending index.
  - DEVICE_FIRST=1: head = b_select_out. Each listed device's selection_x = previous hop, where a hop is the head or the prior listed device's selection_y. a_select_out = last hop. b_select_in = a_select_in.
  - DEVICE_FIRST=0: a_select_out = b_select_out; head = a_select_in; tail → b_select_in.
  - Bypassed device: selection_x = 0.
  - All devices bypassed: chain degenerates to a direct wire, identical to the two-way BYPASS case.
- Ownership FSM, states IDLE and CONNECTED. Let opv = {a_operational_in, dev_operational_in}.
  - IDLE → CONNECTED when exactly one bit of opv is 1; owner ← its index.
  - IDLE with ≥2 bits set: stay IDLE; contention pulse.
  - CONNECTED → IDLE when opv[owner] = 0, or when b_operational_out = 0. The latter forces IDLE from any state, same cycle.
  - CONNECTED with any non-owner opv bit = 1: contention pulse; stay CONNECTED.
- Inbound merge:
  - request_in is always the OR of A and all devices.
  - IDLE: bus_in, operational_in, address_in, status_in and service_in are the OR of A and all devices.
  - CONNECTED: those same signals come from the owner only; non-owner contributions are masked.
  - The masking decision uses the state registered in the previous cycle. The first connection cycle is therefore OR-merged.
- contention_count: +1 per contention pulse, saturates at 255, no wrap.
- Reset mid-connection: immediate IDLE; counters and sticky cleared.

Optional Feature:
- Macro CHANNEL_TEE_N_CONTENTION_COUNT_EN.
- Defined: contention_count implemented as above.
- Undefined: counter logic omitted; contention_count tied to 0. The contention pulse and contention_sticky remain.

Test Plan:
- N=3, DEVICE_FIRST=1, mask 0; b_select_out=1, dev_selection_y loops back x for devices 0–1, device 2 holds y=0 → dev_selection_x=3'b111 after settling, a_select_out=0; device 2 raises operational_in → next cycle connected=1, owner=2, b_operational_in=1.
- Connected owner=2; device 0 drives dev_bus_in=8'hA5, device 2 drives 8'h3C → b_bus_in=8'h3C; contention=0; request_in from device 0 still reaches b_request_in.
- IDLE; devices 0 and 1 raise operational_in the same cycle → contention pulse 1 clk, sticky=1, count=1, connected=0, b_operational_in=1.
- Connected owner=N (A); drop b_operational_out → connected=0 next cycle; 260 forced contentions → count=255.
- DEVICE_FIRST=0, BYPASS_MASK=3'b010 → dev_selection_x[1] stays 0; a_select_in=1 propagates via devices 0, 2 to b_select_in; a_select_out follows b_select_out.
- Reset asserted while connected → all outputs 0 the following cycle; with the macro undefined, contention_count stays 0 throughout.
